// File: rtl/stack_arb_pkg.sv
// Shared encodings and helpers for the stack_arbiter block.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld       = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack controller between NUM_REQ requesters.
// Optional WAIT-state timeout enabled by defining STACK_ARB_TIMEOUT_EN.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_push,
  input  logic [NUM_REQ-1:0]        req_pop,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      stk_user_push,
  output logic                      stk_user_pop,
  output logic [DATA_W-1:0]         stk_wdata,
  input  logic                      stk_ready,
  input  logic                      stk_push,
  input  logic                      stk_pop,
  input  logic                      stk_overflow,
  input  logic                      stk_underflow,
  input  logic [DATA_W-1:0]         stk_rdata
);

  localparam int IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("stack_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef STACK_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]  active;
  logic [NUM_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_vld;
  logic [DATA_W-1:0]   sel_data;
  logic                ok_hit;
  logic                err_hit;

  assign active = req_push | req_pop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (active),
    .ptr       (rr_q),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .grant_vld (win_vld)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data |= win_oh[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
    end
  end

  // Only status matching the outstanding op counts; everything else is noise.
  always_comb begin
    ok_hit  = (op_q == OP_PUSH) ? stk_push     : stk_pop;
    err_hit = (op_q == OP_PUSH) ? stk_overflow : stk_underflow;
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    data_d        = data_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
`ifdef STACK_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    stk_user_push = 1'b0;
    stk_user_pop  = 1'b0;
    stk_wdata     = '0;
    req_ack       = '0;
    req_err       = '0;
    rdata         = '0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          op_d    = (|(req_pop & win_oh)) ? OP_POP : OP_PUSH;
          data_d  = sel_data;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        stk_wdata = data_q;
        if (stk_ready) begin
          stk_user_push = (op_q == OP_PUSH);
          stk_user_pop  = (op_q == OP_POP);
          state_d       = WAIT;
`ifdef STACK_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end

      WAIT: begin
        stk_wdata = data_q;
`ifdef STACK_ARB_TIMEOUT_EN
        cnt_d     = cnt_q + 1'b1;
`endif
        if (err_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (ok_hit) begin
          err_d   = 1'b0;
          rdata_d = (op_q == OP_POP) ? stk_rdata : '0;
          state_d = RESP;
        end
`ifdef STACK_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
`endif
      end

      RESP: begin
        stk_wdata        = data_q;
        req_ack[grant_q] = 1'b1;
        req_err[grant_q] = err_q;
        rdata            = rdata_q;
        rr_d             = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d          = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_PUSH;
      grant_q <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef STACK_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter (NUM_REQ=2, DATA_W=8); timeout checks follow STACK_ARB_TIMEOUT_EN.
module tb_stack_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_push, req_pop;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack, req_err;
  logic [7:0]  rdata;
  logic        stk_user_push, stk_user_pop;
  logic [7:0]  stk_wdata;
  logic        stk_ready, stk_push, stk_pop, stk_overflow, stk_underflow;
  logic [7:0]  stk_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  stack_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_push      (req_push),
    .req_pop       (req_pop),
    .req_wdata     (req_wdata),
    .req_ack       (req_ack),
    .req_err       (req_err),
    .rdata         (rdata),
    .stk_user_push (stk_user_push),
    .stk_user_pop  (stk_user_pop),
    .stk_wdata     (stk_wdata),
    .stk_ready     (stk_ready),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_overflow  (stk_overflow),
    .stk_underflow (stk_underflow),
    .stk_rdata     (stk_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] push, pop;
    logic [7:0] wd0, wd1;
    logic       rdy, sp, spop, so, su;
    logic [7:0] srd;
    logic [1:0] e_ack, e_err;
    logic [7:0] e_rd;
    logic       e_up, e_upop;
    logic [7:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [1:0] push, input logic [1:0] pop,
                   input logic [7:0] wd0, input logic [7:0] wd1,
                   input logic rdy, input logic sp, input logic spop,
                   input logic so, input logic su, input logic [7:0] srd,
                   input logic [1:0] e_ack, input logic [1:0] e_err,
                   input logic [7:0] e_rd, input logic e_up, input logic e_upop,
                   input logic [7:0] e_wd);
    vec_t t;
    t.push = push; t.pop = pop; t.wd0 = wd0; t.wd1 = wd1;
    t.rdy = rdy; t.sp = sp; t.spop = spop; t.so = so; t.su = su; t.srd = srd;
    t.e_ack = e_ack; t.e_err = e_err; t.e_rd = e_rd;
    t.e_up = e_up; t.e_upop = e_upop; t.e_wd = e_wd;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [21:0] outs();
    return {req_ack, req_err, rdata, stk_user_push, stk_user_pop, stk_wdata};
  endfunction

  logic [1:0] exp_g [4];
  logic [7:0] exp_d [4];
  logic       pend;
  int         n_ack;
  bit         got_ack;

  initial begin
    reset = 1'b1; req_push = '0; req_pop = '0; req_wdata = '0;
    stk_ready = 1'b0; stk_push = 1'b0; stk_pop = 1'b0;
    stk_overflow = 1'b0; stk_underflow = 1'b0; stk_rdata = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", outs(), 22'd0);
    reset = 1'b1;

    // push,pop,wd0,wd1, rdy,sp,spop,so,su,srd, e_ack,e_err,e_rd,e_up,e_upop,e_wd
    // single push A5 from requester 0
    v(2'b01,2'b00,8'hA5,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b01,2'b00,8'hA5,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,1,0,8'hA5);
    v(2'b01,2'b00,8'hA5,8'h00, 1,1,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'hA5);
    v(2'b01,2'b00,8'hA5,8'h00, 1,0,0,0,0,8'h00, 2'b01,2'b00,8'h00,0,0,8'hA5);
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    // requester 0 pushes 3C (pointer wraps to 0), requester 1 pops it back
    v(2'b01,2'b00,8'h3C,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b01,2'b00,8'h3C,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,1,0,8'h3C);
    v(2'b01,2'b00,8'h3C,8'h00, 1,1,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h3C);
    v(2'b01,2'b00,8'h3C,8'h00, 1,0,0,0,0,8'h00, 2'b01,2'b00,8'h00,0,0,8'h3C);
    v(2'b00,2'b10,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b00,2'b10,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,1,8'h00);
    v(2'b00,2'b10,8'h00,8'h00, 1,0,1,0,0,8'h3C, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b00,2'b10,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b10,2'b00,8'h3C,0,0,8'h00);
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    // spurious status while idle
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,1,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b00,2'b00,8'h00,8'h00, 1,1,1,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    // underflow on pop; a stray overflow in WAIT is ignored first
    v(2'b00,2'b01,8'h77,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b00,2'b01,8'h77,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,1,8'h77);
    v(2'b00,2'b01,8'h77,8'h00, 1,0,0,1,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h77);
    v(2'b00,2'b01,8'h77,8'h00, 1,0,0,0,1,8'h99, 2'b00,2'b00,8'h00,0,0,8'h77);
    v(2'b00,2'b01,8'h77,8'h00, 1,0,0,0,0,8'h00, 2'b01,2'b01,8'h00,0,0,8'h77);
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    // requester 1 push held off by stk_ready=0 for five ISSUE cycles
    v(2'b10,2'b00,8'h00,8'h5A, 0,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b10,2'b00,8'h00,8'h5A, 0,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 0,1,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 0,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 0,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 0,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,1,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 1,1,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h5A);
    v(2'b10,2'b00,8'h00,8'h5A, 1,0,0,0,0,8'h00, 2'b10,2'b00,8'h00,0,0,8'h5A);
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    // push and pop together: pop wins, stray push strobe ignored
    v(2'b01,2'b01,8'h66,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);
    v(2'b01,2'b01,8'h66,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,1,8'h66);
    v(2'b01,2'b01,8'h66,8'h00, 1,1,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h66);
    v(2'b01,2'b01,8'h66,8'h00, 1,0,1,0,0,8'h44, 2'b00,2'b00,8'h00,0,0,8'h66);
    v(2'b01,2'b01,8'h66,8'h00, 1,0,0,0,0,8'h00, 2'b01,2'b00,8'h44,0,0,8'h66);
    v(2'b00,2'b00,8'h00,8'h00, 1,0,0,0,0,8'h00, 2'b00,2'b00,8'h00,0,0,8'h00);

    foreach (vecs[i]) begin
      @(negedge clk);
      req_push = vecs[i].push; req_pop = vecs[i].pop;
      req_wdata = {vecs[i].wd1, vecs[i].wd0};
      stk_ready = vecs[i].rdy; stk_push = vecs[i].sp; stk_pop = vecs[i].spop;
      stk_overflow = vecs[i].so; stk_underflow = vecs[i].su; stk_rdata = vecs[i].srd;
      #1 check($sformatf("vec%0d", i), outs(),
               {vecs[i].e_ack, vecs[i].e_err, vecs[i].e_rd,
                vecs[i].e_up, vecs[i].e_upop, vecs[i].e_wd});
    end
    stk_push = 1'b0; stk_pop = 1'b0; stk_overflow = 1'b0;
    stk_underflow = 1'b0; stk_rdata = '0; stk_ready = 1'b1;

    // reset in WAIT after a completed grant to 0 (pointer now 1)
    @(negedge clk); req_push = 2'b01; req_wdata = {8'h00, 8'hAB};
    @(negedge clk); #1 check("rst_issue_cmd", stk_user_push, 1);
    @(negedge clk); #1 check("rst_wait_wdata", stk_wdata, 8'hAB);
    #1 reset = 1'b0;
    #1 check("rst_async_outputs", outs(), 22'd0);
    req_push = 2'b00;
    @(negedge clk); reset = 1'b1;

    // contention: both push continuously, first grant must be 0 after reset
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
    @(negedge clk); req_push = 2'b11; req_wdata = {8'h22, 8'h11};
    pend = 1'b0; n_ack = 0;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      if (c > 0) @(negedge clk);
      stk_push = pend;
      #1;
      pend = stk_user_push;
      if (stk_user_push) check($sformatf("cont_wdata%0d", n_ack), stk_wdata, exp_d[n_ack]);
      if (|req_ack) begin
        check($sformatf("cont_grant%0d", n_ack), {req_ack, req_err}, {exp_g[n_ack], 2'b00});
        n_ack++;
      end
    end
    if (n_ack < 4) check("cont_done", n_ack, 4);
    req_push = 2'b00; stk_push = 1'b0;

    // requester 1 push with no status ever returned
    @(negedge clk); req_push = 2'b10; req_wdata = {8'h5E, 8'h00};
    got_ack = 1'b0;
`ifdef STACK_ARB_TIMEOUT_EN
    for (int c = 0; c < 40 && !got_ack; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (|req_ack) begin
        got_ack = 1'b1;
        check("timeout_latency", c, 17);
        check("timeout_ack", {req_ack, req_err, rdata}, {2'b10, 2'b10, 8'h00});
      end
    end
    if (!got_ack) check("timeout_ack_seen", 0, 1);
    req_push = 2'b00;
`else
    n_ack = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (|req_ack) n_ack++;
    end
    check("no_timeout_ack", n_ack, 0);
    req_push = 2'b00;
    #1 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
`endif
    @(negedge clk);
    #1 check("final_idle", outs(), 22'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one stack (controller plus storage) between NUM_REQ requesters, e.g. the 8-queen placement engine and a debug/readback port.
- Each requester issues push or pop commands through a req/ack handshake.
- The arbiter picks one requester round-robin, sequences the stack controller's user_push/user_pop/ready strobes, and returns per-requester ack, error and pop data.
- Sits between the requesters and the stack controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DATA_W, 8, stack data width
- TIMEOUT, 15, max cycles spent in WAIT before forcing an error (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req_push  input  NUM_REQ  per-requester push request
- req_pop  input  NUM_REQ  per-requester pop request
- req_wdata  input  NUM_REQ*DATA_W  push data; slice i belongs to requester i
- req_ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  output  NUM_REQ  qualifies req_ack: overflow, underflow or timeout
- rdata  output  DATA_W  pop result; valid with req_ack
- stk_user_push  output  1  push command to stack controller
- stk_user_pop  output  1  pop command to stack controller
- stk_wdata  output  DATA_W  data presented to stack storage
- stk_ready, stk_push, stk_pop, stk_overflow, stk_underflow  input  1 each  stack controller status strobes
- stk_rdata  input  DATA_W  stack top data

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; rr pointer 0; all outputs 0; latched grant, op and data cleared. Reset asserted mid-operation abandons the command; no ack is issued.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - A requester is active if req_push[i] | req_pop[i].
  - Grant goes to the first active index at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch grant index, op and req_wdata slice; go to ISSUE.
  - If req_push[i] and req_pop[i] are both set, pop wins.
  - No active requester: stay in IDLE.
- ISSUE:
  - stk_wdata holds the latched data from ISSUE through RESP.
  - If stk_ready=1: drive stk_user_push or stk_user_pop for exactly this cycle, then go to WAIT.
  - If stk_ready=0: stay in ISSUE, commands deasserted.
- WAIT:
  - stk_push / stk_pop: success.
  - stk_overflow / stk_underflow: error. Status is valid only if it matches the op: push accepts push/overflow, pop accepts pop/underflow.
  - On pop success, capture stk_rdata.
  - Non-matching strobes are ignored.
  - Go to RESP after the first matching strobe.
- RESP:
  - req_ack[g]=1 and req_err[g] set for one cycle; rdata valid (0 on push or error).
  - rr pointer <= (g+1) mod NUM_REQ; go to IDLE.
- Status strobes arriving while in IDLE, ISSUE or RESP are ignored. The stack controller pulses status with no command outstanding, so the arbiter never infers results outside WAIT.
- Latency: with stk_ready=1 and the status strobe one cycle after the command, req to ack is 4 cycles. The grant cannot change until RESP completes.
- Requester obligations:
  - Hold the request until ack.
  - Deasserting after latch does not cancel: the command completes and ack still pulses.
  - Deasserting before latch drops the request silently.
- Fairness: with all requesters continuously active, grants rotate 0,1,...,NUM_REQ-1.

Optional Feature:
- Macro STACK_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT forces RESP with req_err=1 and rdata=0.
- Undefined: no counter; WAIT lasts until a matching strobe; TIMEOUT is unused.

Decomposition:
- Package stack_arb_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - op encoding: OP_PUSH=1'b0, OP_POP=1'b1
- Sub-module rr_arbiter: combinational round-robin pick from request vector plus pointer; outputs one-hot grant and index.

Test Plan:
- Single push: requester 0 pushes 8'hA5, stack not full -> stk_user_push one cycle, req_ack[0]=1 with req_err[0]=0 four cycles after request; stk_wdata=8'hA5.
- Push then pop: requester 1 pops after 0 pushes 8'h3C -> req_ack[1]=1, rdata=8'h3C, req_err[1]=0.
- Underflow: pop on empty stack (stk_underflow strobe) -> req_ack[0]=1, req_err[0]=1, rdata=0.
- Contention: both requesters push continuously (0x11 and 0x22) -> grants alternate 0,1,0,1; no requester waits more than one full transaction.
- Robustness: spurious stk_overflow while arbiter is IDLE -> no ack, no state change. stk_ready=0 for 5 cycles during ISSUE -> command issued only on the first cycle stk_ready=1.
- Reset and timeout: reset asserted in WAIT -> all outputs 0 immediately and next grant starts at 0. With STACK_ARB_TIMEOUT_EN and no strobe -> req_ack with req_err=1 after 15 WAIT cycles.
